// File: rtl/my_rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader.
package my_loader_pkg;

    localparam int         BYTE_W       = 8;
    localparam logic [7:0] LEN_MSB_MASK = 8'h80;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CKSUM,
        S_RUN,
        S_ERROR
    } state_t;

    // True while the loader is consuming the image byte stream.
    function automatic logic is_loading(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CKSUM);
    endfunction

endpackage

// File: rtl/my_word_assembler.sv
// Builds 16-bit instruction words from byte pairs (high byte first)
// and issues a registered one-cycle write to the instruction ROM.
module my_word_assembler
    import my_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              hi_load,
    input  logic              lo_load,
    input  logic [ADDR_W-1:0] word_addr,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_data
);

    logic [BYTE_W-1:0] hi_q;

    // Latch the high byte of the current word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
        end else if (hi_load) begin
            hi_q <= byte_in;
        end
    end

    // Strobe the ROM for one cycle after the low byte; address/data hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
        end else begin
            rom_we <= lo_load;
            if (lo_load) begin
                rom_addr <= word_addr;
                rom_data <= DATA_W'({hi_q, byte_in});
            end
        end
    end

endmodule

// File: rtl/my_rom_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte image into the
// instruction ROM and holds the CPU in reset until the image is verified.
module my_rom_loader
    import my_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    state_t            state;
    state_t            state_next;
    logic [BYTE_W-1:0] len_hi_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTE_W-1:0] sum_q;
    logic              accept;
    logic [ADDR_W-1:0] len_word;
    logic              restart;

    // Ready depends on state alone so the upstream handshake never loops back.
    assign byte_ready = is_loading(state);
    assign accept     = byte_valid & byte_ready;
    assign len_word   = ADDR_W'({len_hi_q, byte_in});
    assign restart    = ((state == S_RUN) || (state == S_ERROR)) && load_req;

    // Next-state decode; only accepted bytes or a restart request move the FSM.
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI:  if (accept) state_next = ((byte_in & LEN_MSB_MASK) != '0) ? S_ERROR : S_LEN_LO;
            S_LEN_LO:  if (accept) state_next = (len_word == '0) ? S_CKSUM : S_DATA_HI;
            S_DATA_HI: if (accept) state_next = S_DATA_LO;
            S_DATA_LO: if (accept) state_next = (addr_q == (len_q - ADDR_W'(1))) ? S_CKSUM : S_DATA_HI;
            S_CKSUM:   if (accept) state_next = (byte_in == sum_q) ? S_RUN : S_ERROR;
            S_RUN,
            S_ERROR:   if (load_req) state_next = S_LEN_HI;
            default:   state_next = S_LEN_HI;
        endcase
    end

    // State, counters, checksum and status outputs registered from next-state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_LEN_HI;
            len_hi_q  <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            sum_q     <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_reset <= (state_next != S_RUN);
            done      <= (state_next == S_RUN);
            error     <= (state_next == S_ERROR);
            if (restart) begin
                len_hi_q <= '0;
                len_q    <= '0;
                addr_q   <= '0;
                sum_q    <= '0;
            end else if (accept) begin
                if (state != S_CKSUM) sum_q <= sum_q + byte_in;
                if (state == S_LEN_HI) len_hi_q <= byte_in;
                if (state == S_LEN_LO) len_q <= len_word;
                if (state == S_DATA_LO) addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    my_word_assembler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_word (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .hi_load   (accept && (state == S_DATA_HI)),
        .lo_load   (accept && (state == S_DATA_LO)),
        .word_addr (addr_q),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

endmodule
